// File: rtl/reset_seq_pkg.sv
// Shared encodings for the SoC reset sequencer: FSM states, reset-cause codes
// and a small helper used to size counters.
package reset_seq_pkg;

    typedef enum logic [2:0] {
        StHold      = 3'd0,
        StPorWait   = 3'd1,
        StPeriphRel = 3'd2,
        StRun       = 3'd3,
        StSoft      = 3'd4
    } seq_state_e;

    typedef enum logic [1:0] {
        CAUSE_POR  = 2'b00,
        CAUSE_LOCK = 2'b01,
        CAUSE_SOFT = 2'b10,
        CAUSE_WDOG = 2'b11
    } cause_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer with asynchronous active-low clear.
// Used for PLL lock here and for PS/2 and UART RX inputs elsewhere.
module sync_2ff (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/reset_sequencer.sv
// Staged system-reset sequencer for the 6502 SoC: lock filter, power-on delay,
// peripheral then CPU release, plus soft reset, watchdog and lock-loss handling.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int unsigned LOCK_FILT   = 16,
    parameter int unsigned POR_CYCLES  = 256,
    parameter int unsigned CPU_DLY     = 16,
    parameter int unsigned SOFT_CYCLES = 32,
    parameter int unsigned WDOG_BITS   = 20
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       pll_lock,
    input  logic       soft_req,
    input  logic       wdog_en,
    input  logic       wdog_kick,
    output logic       periph_reset,
    output logic       cpu_reset,
    output logic       running,
    output logic [1:0] cause,
    output logic [2:0] state
);

    localparam int unsigned CNT_MAX = max_u(max_u(LOCK_FILT, POR_CYCLES),
                                            max_u(CPU_DLY, SOFT_CYCLES));
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_FILT - 1);
    localparam logic [CNT_W-1:0] POR_LAST    = CNT_W'(POR_CYCLES - 1);
    localparam logic [CNT_W-1:0] CPU_LAST    = CNT_W'(CPU_DLY - 1);
    localparam logic [CNT_W-1:0] SOFT_LAST   = CNT_W'(SOFT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [WDOG_BITS-1:0] WDOG_ONE = WDOG_BITS'(1);

    seq_state_e           r_state;
    seq_state_e           w_state_d;
    cause_e               r_cause;
    cause_e               w_cause_d;
    logic [CNT_W-1:0]     r_filt;
    logic [CNT_W-1:0]     w_filt_d;
    logic [CNT_W-1:0]     r_cnt;
    logic [CNT_W-1:0]     w_cnt_d;
    logic [WDOG_BITS-1:0] r_wdog;
    logic [WDOG_BITS-1:0] w_wdog_d;
    logic                 r_periph_reset;
    logic                 r_cpu_reset;
    logic                 r_running;
    logic                 w_periph_d;
    logic                 w_cpu_d;
    logic                 w_running_d;
    logic                 w_lock_s;
    logic                 w_lock_loss;
    logic                 w_wdog_expire;

    sync_2ff u_lock_sync (
        .i_clk   (clk),
        .i_rst_n (reset_n),
        .i_d     (pll_lock),
        .o_q     (w_lock_s)
    );

    assign w_lock_loss   = (r_state != StHold) && !w_lock_s;
    // A kick landing on the expiry cycle rescues the system.
    assign w_wdog_expire = (r_state == StRun) && wdog_en && (r_wdog == '1) && !wdog_kick;

    always_comb begin
        w_state_d = r_state;
        w_cause_d = r_cause;
        w_filt_d  = r_filt;
        w_cnt_d   = r_cnt;

        case (r_state)
            StHold: begin
                if (!w_lock_s) begin
                    w_filt_d = '0;
                end else if (r_filt == LOCK_LAST) begin
                    w_state_d = StPorWait;
                end else begin
                    w_filt_d = r_filt + CNT_ONE;
                end
            end
            StPorWait: begin
                if (r_cnt == POR_LAST) begin
                    w_state_d = StPeriphRel;
                end else begin
                    w_cnt_d = r_cnt + CNT_ONE;
                end
            end
            StPeriphRel: begin
                if (r_cnt == CPU_LAST) begin
                    w_state_d = StRun;
                end else begin
                    w_cnt_d = r_cnt + CNT_ONE;
                end
            end
            StRun: begin
                if (w_wdog_expire) begin
                    w_state_d = StSoft;
                    w_cause_d = CAUSE_WDOG;
                end else if (soft_req) begin
                    w_state_d = StSoft;
                    w_cause_d = CAUSE_SOFT;
                end
            end
            StSoft: begin
                // Soft reset skips the lock filter and goes straight to the POR delay.
                if (r_cnt == SOFT_LAST) begin
                    w_state_d = StPorWait;
                end else begin
                    w_cnt_d = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_d = StHold;
            end
        endcase

        if (w_lock_loss) begin
            w_state_d = StHold;
            w_cause_d = CAUSE_LOCK;
        end

        if (w_state_d != r_state) begin
            w_cnt_d  = '0;
            w_filt_d = '0;
        end
    end

    always_comb begin
        w_wdog_d = '0;
        if ((r_state == StRun) && (w_state_d == StRun) && wdog_en && !wdog_kick) begin
            w_wdog_d = r_wdog + WDOG_ONE;
        end
    end

    // Pin values are decoded from the next state so they register alongside it.
    always_comb begin
        w_periph_d  = 1'b1;
        w_cpu_d     = 1'b1;
        w_running_d = 1'b0;
        case (w_state_d)
            StPeriphRel: begin
                w_periph_d = 1'b0;
            end
            StRun: begin
                w_periph_d  = 1'b0;
                w_cpu_d     = 1'b0;
                w_running_d = 1'b1;
            end
            default: begin
                w_periph_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= StHold;
            r_cause        <= CAUSE_POR;
            r_filt         <= '0;
            r_cnt          <= '0;
            r_wdog         <= '0;
            r_periph_reset <= 1'b1;
            r_cpu_reset    <= 1'b1;
            r_running      <= 1'b0;
        end else begin
            r_state        <= w_state_d;
            r_cause        <= w_cause_d;
            r_filt         <= w_filt_d;
            r_cnt          <= w_cnt_d;
            r_wdog         <= w_wdog_d;
            r_periph_reset <= w_periph_d;
            r_cpu_reset    <= w_cpu_d;
            r_running      <= w_running_d;
        end
    end

    assign periph_reset = r_periph_reset;
    assign cpu_reset    = r_cpu_reset;
    assign running      = r_running;
    assign cause        = r_cause;
    assign state        = r_state;

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Sequences system reset for the 6502 SoC, replacing the free-running power-on counter at top level.
- Releases reset in stages:
  - waits for PLL lock to be stable;
  - runs a power-on delay;
  - releases peripherals (video, UART, SPI, PS/2, LED);
  - releases the CPU after a further delay.
- Also handles CPU-initiated soft reset, a watchdog, and PLL lock loss, and records the cause of the last reset for firmware.

Parameters:
- LOCK_FILT, 16: consecutive synchronized lock-high cycles required before leaving HOLD.
- POR_CYCLES, 256: cycles spent in POR_WAIT (16 us at 16 MHz).
- CPU_DLY, 16: cycles between peripheral release and CPU release.
- SOFT_CYCLES, 32: cycles both resets are held during soft or watchdog reset.
- WDOG_BITS, 20: watchdog counter width; timeout is 2^WDOG_BITS-1 cycles.

Ports:
- clk  in  1  system clock (PLL output).
- reset_n  in  1  asynchronous, active-low master reset.
- pll_lock  in  1  raw PLL LOCK, asynchronous to clk.
- soft_req  in  1  single-cycle soft-reset request from CPU register write (clk domain).
- wdog_en  in  1  watchdog enable level from CPU control register.
- wdog_kick  in  1  single-cycle watchdog service pulse.
- periph_reset  out  1  active-high reset to peripherals.
- cpu_reset  out  1  active-high reset to the CPU core.
- running  out  1  high only in RUN.
- cause  out  2  last reset cause: 00 POR, 01 lock loss, 10 soft, 11 watchdog.
- state  out  3  current FSM state, for diagnostics.

Behaviour:
- Reset:
  - While reset_n is low: state=HOLD, periph_reset=1, cpu_reset=1, running=0, cause=00, all counters 0.
  - Every flop is cleared asynchronously.
- Lock synchronizer:
  - pll_lock passes through a 2-FF synchronizer to give lock_s.
  - Latency is 2 clk cycles.
  - The synchronizer is also cleared by reset_n.
- Outputs are registered directly from the state register; there is no combinational decode to pins.
- Per-state output values:
  - HOLD, POR_WAIT, SOFT: periph_reset=1, cpu_reset=1.
  - PERIPH_REL: periph_reset=0, cpu_reset=1.
  - RUN: periph_reset=0, cpu_reset=0, running=1.
- FSM transitions:
  - HOLD: filt_cnt increments while lock_s=1 and clears to 0 when lock_s=0. Go to POR_WAIT on the cycle filt_cnt reaches LOCK_FILT-1 with lock_s=1.
  - POR_WAIT: cnt counts 0..POR_CYCLES-1, then go to PERIPH_REL and clear cnt.
  - PERIPH_REL: cnt counts 0..CPU_DLY-1, then go to RUN.
  - RUN:
    - soft_req=1 → SOFT, cause=10.
    - Watchdog expiry → SOFT, cause=11.
  - SOFT: cnt counts 0..SOFT_CYCLES-1, then go to POR_WAIT. The lock filter is not repeated.
- Resulting timing, with lock_s=1 at cycle 0 of HOLD:
  - periph_reset falls at cycle LOCK_FILT+POR_CYCLES.
  - cpu_reset falls at cycle LOCK_FILT+POR_CYCLES+CPU_DLY.
- Lock loss:
  - lock_s=0 in any state other than HOLD sends the FSM to HOLD and sets cause=01.
  - Both resets assert on the next cycle.
- Priority when events coincide in one cycle: lock loss > watchdog expiry > soft_req.
- soft_req outside RUN is ignored; it is not queued.
- Watchdog counter:
  - Counts only in RUN with wdog_en=1.
  - Cleared when wdog_kick=1, when wdog_en=0, or when not in RUN.
  - Expiry is the counter equal to all-ones with wdog_en=1.
  - kick and expiry in the same cycle: kick wins, no reset.
- cause:
  - Updates only on entry to HOLD (lock loss) or SOFT.
  - Holds otherwise, and is readable after the CPU restarts.
  - Cleared to 00 only by reset_n.
- Counter widths are sized by $clog2 of the largest parameter. No counter wraps; every counter is cleared on state change.
- reset_n asserted mid-sequence aborts immediately to the reset values; there is no partial state.

Decomposition:
- Package reset_seq_pkg:
  - state encodings: HOLD=0, POR_WAIT=1, PERIPH_REL=2, RUN=3, SOFT=4;
  - cause codes: CAUSE_POR, CAUSE_LOCK, CAUSE_SOFT, CAUSE_WDOG.
- One sub-module, sync_2ff: a parameter-free single-bit 2-FF synchronizer with async active-low clear. It is reused elsewhere for PS/2 and RX inputs.
- The FSM, counters and watchdog stay in reset_sequencer.

Test Plan:
- Power-up: release reset_n with pll_lock=1 → periph_reset falls exactly 2+16+256=274 cycles after the first clk edge; cpu_reset falls 16 cycles later; running=1; cause=00.
- Lock glitch during HOLD: drop pll_lock for 1 cycle at lock_s filter count 10 → filter restarts; periph_reset falls 16+256 cycles after lock_s returns high.
- Lock loss in RUN: deassert pll_lock → cpu_reset and periph_reset return to 1 within 3 cycles; cause=01; full sequence repeats when lock returns.
- Soft reset: pulse soft_req in RUN → both resets held 32 cycles, then POR_WAIT 256, periph release, CPU release 16 later; cause=10. soft_req pulsed in PERIPH_REL → ignored.
- Watchdog (WDOG_BITS=8 override):
  - wdog_en=1, no kick → SOFT entered 255 cycles after RUN entry; cause=11.
  - Kick every 100 cycles → no reset over 2000 cycles.
  - Kick coincident with expiry → no reset.
- Priority: soft_req, watchdog expiry and lock loss in the same cycle → HOLD; cause=01.
